// File: rtl/lu_check_pkg.sv
// Shared types and constants for the logic-unit response checker.
// Holds the FSM state type, response bit positions and default run length.
package lu_check_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCheck,
        StDone
    } state_e;

    localparam int unsigned Z_W   = 3;
    localparam int unsigned Z_AND = 2;
    localparam int unsigned Z_OR  = 1;
    localparam int unsigned Z_XOR = 0;

    localparam int unsigned DEFAULT_NUM_VEC = 4;

endpackage

// File: rtl/lu_ref_model.sv
// Golden combinational model of the logic unit under test.
// Produces the expected AND/OR/XOR response for operands a and b.
module lu_ref_model
    import lu_check_pkg::*;
(
    input  logic           a,
    input  logic           b,
    output logic [Z_W-1:0] z
);

    always_comb begin
        z        = '0;
        z[Z_AND] = a & b;
        z[Z_OR]  = a | b;
        z[Z_XOR] = a ^ b;
    end

endmodule

// File: rtl/lu_resp_checker.sv
// Checks logic-unit responses against a reference model over a run of NUM_VEC vectors,
// tracking vector/error counts, operand coverage and the first failing vector.
module lu_resp_checker
    import lu_check_pkg::*;
#(
    parameter int unsigned NUM_VEC     = DEFAULT_NUM_VEC,
    parameter int unsigned CNT_W       = 8,
    parameter bit          STOP_ON_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic             in_a,
    input  logic             in_b,
    input  logic [Z_W-1:0]   in_z,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [Z_W-1:0]   first_err_z,
    output logic [3:0]       cov
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   vec_count_q, vec_count_d;
    logic [CNT_W-1:0]   err_count_q, err_count_d;
    logic [CNT_W-1:0]   first_err_idx_q, first_err_idx_d;
    logic [Z_W-1:0]     first_err_z_q, first_err_z_d;
    logic [3:0]         cov_q, cov_d;

    logic [Z_W-1:0]     exp_z;
    logic               accept;
    logic               mismatch;
    logic               last_vec;
    logic               clear;
    logic               cov_ok;

    lu_ref_model u_ref_model (
        .a (in_a),
        .b (in_b),
        .z (exp_z)
    );

    assign accept   = in_valid && (state_q == StCheck);
    assign mismatch = accept && (in_z != exp_z);
    assign last_vec = (vec_count_q == CNT_W'(NUM_VEC - 1));
    assign clear    = start && (state_q != StCheck);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StCheck;
            end
            StCheck: begin
                if (accept && (last_vec || (STOP_ON_ERR && mismatch))) state_d = StDone;
            end
            StDone: begin
                if (start) state_d = StCheck;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        vec_count_d     = vec_count_q;
        err_count_d     = err_count_q;
        first_err_idx_d = first_err_idx_q;
        first_err_z_d   = first_err_z_q;
        cov_d           = cov_q;
        if (clear) begin
            vec_count_d     = '0;
            err_count_d     = '0;
            first_err_idx_d = '0;
            first_err_z_d   = '0;
            cov_d           = '0;
        end else if (accept) begin
            vec_count_d           = vec_count_q + 1'b1;
            cov_d[{in_a, in_b}]   = 1'b1;
            if (mismatch) begin
                // A zero error count means this is the first mismatch of the run.
                if (err_count_q == '0) begin
                    first_err_idx_d = vec_count_q;
                    first_err_z_d   = in_z;
                end
                if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            vec_count_q     <= '0;
            err_count_q     <= '0;
            first_err_idx_q <= '0;
            first_err_z_q   <= '0;
            cov_q           <= '0;
        end else begin
            state_q         <= state_d;
            vec_count_q     <= vec_count_d;
            err_count_q     <= err_count_d;
            first_err_idx_q <= first_err_idx_d;
            first_err_z_q   <= first_err_z_d;
            cov_q           <= cov_d;
        end
    end

    // Full coverage is only reachable when the run is long enough to hit every combination.
    assign cov_ok = (NUM_VEC < 4) || (cov_q == 4'b1111);

    assign in_ready      = (state_q == StCheck);
    assign busy          = (state_q == StCheck);
    assign done          = (state_q == StDone);
    assign pass          = done && (err_count_q == '0) &&
                           (vec_count_q == CNT_W'(NUM_VEC)) && cov_ok;
    assign vec_count     = vec_count_q;
    assign err_count     = err_count_q;
    assign first_err_idx = first_err_idx_q;
    assign first_err_z   = first_err_z_q;
    assign cov           = cov_q;

endmodule

// File: tb/tb_lu_resp_checker.sv
// Directed bench for lu_resp_checker: one instance runs to completion, a second stops on error.
module tb_lu_resp_checker;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       in_valid;
    logic       in_a;
    logic       in_b;
    logic [2:0] in_z;

    logic       rdy0, busy0, done0, pass0;
    logic [7:0] vec0, err0, fidx0;
    logic [2:0] fz0;
    logic [3:0] cov0;

    logic       rdy1, busy1, done1, pass1;
    logic [7:0] vec1, err1, fidx1;
    logic [2:0] fz1;
    logic [3:0] cov1;

    int n_checks = 0;
    int n_pass   = 0;

    lu_resp_checker #(.NUM_VEC(4), .CNT_W(8), .STOP_ON_ERR(1'b0)) u_dut (
        .clk (clk), .rst_n (rst_n), .start (start), .in_valid (in_valid),
        .in_a (in_a), .in_b (in_b), .in_z (in_z),
        .in_ready (rdy0), .busy (busy0), .done (done0), .pass (pass0),
        .vec_count (vec0), .err_count (err0), .first_err_idx (fidx0),
        .first_err_z (fz0), .cov (cov0)
    );

    lu_resp_checker #(.NUM_VEC(4), .CNT_W(8), .STOP_ON_ERR(1'b1)) u_dut_stop (
        .clk (clk), .rst_n (rst_n), .start (start), .in_valid (in_valid),
        .in_a (in_a), .in_b (in_b), .in_z (in_z),
        .in_ready (rdy1), .busy (busy1), .done (done1), .pass (pass1),
        .vec_count (vec1), .err_count (err1), .first_err_idx (fidx1),
        .first_err_z (fz1), .cov (cov1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Called at a negedge; presents one sample across the next rising edge.
    task automatic drive(input logic v, input logic a, input logic b, input logic [2:0] z);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_z     = z;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        start    = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_a     = 1'b0;
        in_b     = 1'b0;
        in_z     = 3'b000;
        #12;
        check("rst_ready", 32'(rdy0), 0);
        check("rst_busy", 32'(busy0), 0);
        check("rst_done", 32'(done0), 0);
        check("rst_vec", 32'(vec0), 0);
        check("rst_cov", 32'(cov0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // All four correct vectors
        pulse_start();
        check("t1_busy", 32'(busy0), 1);
        check("t1_ready", 32'(rdy0), 1);
        drive(1, 0, 0, 3'b000);
        drive(1, 0, 1, 3'b011);
        drive(1, 1, 0, 3'b011);
        check("t1_vec3", 32'(vec0), 3);
        check("t1_notdone3", 32'(done0), 0);
        drive(1, 1, 1, 3'b110);
        check("t1_done", 32'(done0), 1);
        check("t1_busy_lo", 32'(busy0), 0);
        check("t1_pass", 32'(pass0), 1);
        check("t1_vec", 32'(vec0), 4);
        check("t1_err", 32'(err0), 0);
        check("t1_cov", 32'(cov0), 4'b1111);
        check("t1_stop_pass", 32'(pass1), 1);
        drive(1, 1, 1, 3'b000);
        check("t1_frozen_vec", 32'(vec0), 4);
        check("t1_frozen_err", 32'(err0), 0);
        check("t1_held_done", 32'(done0), 1);

        // Vector 2 returns a wrong response
        pulse_start();
        check("t2_cleared_vec", 32'(vec0), 0);
        drive(1, 0, 0, 3'b000);
        drive(1, 0, 1, 3'b011);
        drive(1, 1, 0, 3'b010);
        check("t2_stop_done", 32'(done1), 1);
        check("t2_stop_vec", 32'(vec1), 3);
        drive(1, 1, 1, 3'b110);
        in_valid = 1'b0;
        check("t2_done", 32'(done0), 1);
        check("t2_pass", 32'(pass0), 0);
        check("t2_err", 32'(err0), 1);
        check("t2_fidx", 32'(fidx0), 2);
        check("t2_fz", 32'(fz0), 3'b010);
        check("t2_stop_vec_held", 32'(vec1), 3);
        check("t2_stop_fidx", 32'(fidx1), 2);

        // Vector 1 wrong: stop-on-error instance ends there
        pulse_start();
        drive(1, 0, 0, 3'b000);
        drive(1, 0, 1, 3'b000);
        check("t3_stop_done", 32'(done1), 1);
        check("t3_stop_ready", 32'(rdy1), 0);
        check("t3_stop_vec", 32'(vec1), 2);
        check("t3_stop_err", 32'(err1), 1);
        check("t3_stop_fz", 32'(fz1), 3'b000);
        check("t3_run_busy", 32'(busy0), 1);
        drive(1, 1, 0, 3'b000);
        check("t3_err2", 32'(err0), 2);
        check("t3_fidx_kept", 32'(fidx0), 1);
        drive(1, 1, 1, 3'b110);
        in_valid = 1'b0;
        check("t3_done", 32'(done0), 1);
        check("t3_pass", 32'(pass0), 0);
        check("t3_stop_vec_held", 32'(vec1), 2);

        // Correct but uncovered: four 00 vectors
        pulse_start();
        for (int i = 0; i < 4; i++) drive(1, 0, 0, 3'b000);
        in_valid = 1'b0;
        check("t4_done", 32'(done0), 1);
        check("t4_err", 32'(err0), 0);
        check("t4_cov", 32'(cov0), 4'b0001);
        check("t4_pass", 32'(pass0), 0);

        // Valid in IDLE is ignored, then sparse handshakes with a mid-run start
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 1, 1, 3'b110);
        drive(1, 0, 1, 3'b001);
        check("t5_idle_vec", 32'(vec0), 0);
        check("t5_idle_err", 32'(err0), 0);
        check("t5_idle_cov", 32'(cov0), 0);
        check("t5_idle_busy", 32'(busy0), 0);
        pulse_start();
        drive(1, 0, 0, 3'b000);
        drive(0, 1, 1, 3'b000);
        drive(1, 1, 1, 3'b110);
        start = 1'b1;
        drive(0, 0, 0, 3'b111);
        start = 1'b0;
        check("t5_midstart_busy", 32'(busy0), 1);
        check("t5_midstart_vec", 32'(vec0), 2);
        drive(0, 1, 0, 3'b000);
        drive(1, 0, 1, 3'b011);
        check("t5_vec3", 32'(vec0), 3);
        drive(1, 1, 0, 3'b011);
        in_valid = 1'b0;
        check("t5_done", 32'(done0), 1);
        check("t5_cov", 32'(cov0), 4'b1111);
        check("t5_pass", 32'(pass0), 1);

        // Reset in the middle of a run
        pulse_start();
        drive(1, 0, 0, 3'b000);
        drive(1, 0, 1, 3'b001);
        in_valid = 1'b0;
        check("t6_vec2", 32'(vec0), 2);
        check("t6_err1", 32'(err0), 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_ready", 32'(rdy0), 0);
        check("t6_rst_busy", 32'(busy0), 0);
        check("t6_rst_done", 32'(done0), 0);
        check("t6_rst_pass", 32'(pass0), 0);
        check("t6_rst_vec", 32'(vec0), 0);
        check("t6_rst_err", 32'(err0), 0);
        check("t6_rst_cov", 32'(cov0), 0);
        check("t6_rst_fidx", 32'(fidx0), 0);
        check("t6_rst_fz", 32'(fz0), 0);
        check("t6_rst_stop_done", 32'(done1), 0);
        check("t6_rst_stop_vec", 32'(vec1), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t6_idle_hold", 32'(busy0), 0);
        pulse_start();
        check("t6_fresh_vec", 32'(vec0), 0);
        drive(1, 1, 1, 3'b110);
        in_valid = 1'b0;
        check("t6_new_vec", 32'(vec0), 1);
        check("t6_new_err", 32'(err0), 0);
        check("t6_new_cov", 32'(cov0), 4'b1000);
        check("t6_new_busy", 32'(busy0), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lu_resp_checker.md
LU_RESP_CHECKER -- requirements
Module: lu_resp_checker

Interface
REQ-001 Parameter NUM_VEC, default 4, is the number of vectors accepted per run (1..255).
REQ-002 Parameter CNT_W, default 8, is the width of all counters.
REQ-003 Parameter STOP_ON_ERR, default 0; when 1, the run ends on the first mismatch.
REQ-004 clk  input  1  is the single clock; all state updates occur on its rising edge.
REQ-005 rst_n  input  1  is an asynchronous, active-low reset.
REQ-006 start  input  1  is a one-cycle pulse that begins a run.
REQ-007 in_valid  input  1  marks a response sample as present.
REQ-008 in_a, in_b  input  1 each  are the stimulus operands applied to the logic unit.
REQ-009 in_z  input  3  is the logic-unit response: [2]=a AND b, [1]=a OR b, [0]=a XOR b.
REQ-010 in_ready  output  1  means the checker accepts a sample this cycle.
REQ-011 busy  output  1  is high while the checker is in state CHECK.
REQ-012 done  output  1  is high while the checker is in state DONE.
REQ-013 pass  output  1  is valid while done is high.
REQ-014 vec_count, err_count  output  CNT_W each  are the accepted-vector and mismatch counts.
REQ-015 first_err_idx  output  CNT_W; first_err_z  output  3  record the vector index and in_z of the first mismatch.
REQ-016 cov  output  4  has bit {a,b} set once that operand combination has been accepted.

Function
REQ-017 The FSM shall have the states IDLE, CHECK and DONE.
REQ-018 start in IDLE or DONE shall move the FSM to CHECK and clear all counters, cov, first_err_idx and first_err_z in the same edge.
REQ-019 start while in CHECK shall be ignored.
REQ-020 in_ready shall equal (state==CHECK); a sample is accepted on the edge where in_valid and in_ready are both high.
REQ-021 in_valid outside CHECK shall be ignored, with no counter or cov change.
REQ-022 Expected z shall be computed combinationally from in_a and in_b; a mismatch is in_z != expected.
REQ-023 vec_count, err_count and cov shall update on the accepting edge, so results are visible one cycle after acceptance.
REQ-024 On the first mismatch of a run, first_err_idx shall capture the pre-increment vec_count and first_err_z shall capture in_z.
REQ-025 Later mismatches shall not overwrite first_err_idx or first_err_z.
REQ-026 err_count shall saturate at all-ones; vec_count cannot exceed NUM_VEC.
REQ-027 The FSM shall move CHECK->DONE on the edge that accepts vector NUM_VEC-1.
REQ-028 When STOP_ON_ERR=1, the FSM shall also move CHECK->DONE on the edge that accepts the first mismatch.
REQ-029 In DONE, pass shall be 1 only if err_count==0, vec_count==NUM_VEC, and cov==4'b1111 (cov only when NUM_VEC>=4); pass shall be 0 otherwise.
REQ-030 DONE shall be held, with outputs frozen, until the next start.

Reset
REQ-031 rst_n low shall immediately force IDLE, in_ready=0, busy=0, done=0, pass=0, all counters=0, cov=0, first_err_idx=0 and first_err_z=0.
REQ-032 A reset in the middle of a run shall discard the run; no partial results shall survive the reset.
REQ-033 After rst_n rises, the checker shall remain in IDLE until start.

Structure
REQ-034 The package lu_check_pkg shall hold the state enum, the z bit-position constants (Z_AND=2, Z_OR=1, Z_XOR=0) and the default NUM_VEC.
REQ-035 The sub-module lu_ref_model (combinational a,b -> expected z[2:0]) shall be instantiated once.
REQ-036 The FSM and counters shall reside in lu_resp_checker.

Verification
REQ-037 Reset, start, then 4 correct vectors (00->000, 01->011, 10->011, 11->110), one per cycle -> done after the 4th accept, pass=1, vec_count=4, err_count=0, cov=1111.
REQ-038 Same sequence, but vector 2 returns z=010 -> pass=0, err_count=1, first_err_idx=2, first_err_z=010.
REQ-039 STOP_ON_ERR=1, vector 1 wrong -> DONE on that accept, vec_count=2, in_ready=0 afterwards.
REQ-040 4 correct vectors all 00 -> pass=0 (cov=0001), err_count=0.
REQ-041 in_valid toggled randomly, start pulsed mid-run, in_valid in IDLE -> only accepted handshakes counted, mid-run start ignored.
REQ-042 rst_n asserted after 2 accepts, then a new start -> all outputs 0 during reset, and the fresh run counts from 0.
